// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, word-addressed instruction memory with a load port,
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          freeze,
  input  logic                          branch_taken,
  input  logic [31:0]                   branch_addr,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  output logic [31:0]                   pc,
  output logic [31:0]                   pc_out,
  output logic [31:0]                   instruction,
  output logic                          valid
);

  localparam int unsigned AddrW = $clog2(IMEM_DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      pc_out_q, pc_out_d;
  logic             valid_q, valid_d;
  logic [31:0]      mem_q [IMEM_DEPTH];
  logic [AddrW-1:0] fetch_idx;
  logic [31:0]      fetch_word;
  logic [31:0]      pc_plus4;

  // Upper PC bits are dropped, so fetch addresses alias modulo the memory depth.
  assign fetch_idx  = pc_q[AddrW+1:2];
  assign fetch_word = mem_q[fetch_idx];
  assign pc_plus4   = pc_q + 32'd4;

  // Branch target low bits are forced to zero, so they are never consumed.
  logic unused_branch_lsbs;
  assign unused_branch_lsbs = ^branch_addr[1:0];

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = valid_q;
    if (branch_taken) begin
      // Branch beats freeze: a flushed slot never needs stalling.
      pc_d     = {branch_addr[31:2], 2'b00};
      instr_d  = 32'h0;
      pc_out_d = 32'h0;
      valid_d  = 1'b0;
    end else if (!freeze) begin
      pc_d     = pc_plus4;
      instr_d  = fetch_word;
      pc_out_d = pc_plus4;
      valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc_out_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
    end
  end

  // Memory is not reset; a same-cycle fetch of the written word sees the old contents.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem_q[imem_waddr] <= imem_wdata;
    end
  end

  assign pc          = pc_q;
  assign pc_out      = pc_out_q;
  assign instruction = instr_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: load, sequential fetch, freeze, branch flush,
// wrap/alias, write-vs-fetch ordering and asynchronous reset.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [31:0] pc;
  logic [31:0] pc_out;
  logic [31:0] instruction;
  logic        valid;

  int unsigned errors = 0;
  int unsigned checks = 0;

  localparam logic [31:0] W0   = 32'hE3A0_1005;
  localparam logic [31:0] W1   = 32'hE3A0_2003;
  localparam logic [31:0] W2   = 32'hE081_3002;
  localparam logic [31:0] W3   = 32'hE1A0_0000;
  localparam logic [31:0] W16  = 32'hA0A0_0016;
  localparam logic [31:0] W255 = 32'hFFFF_00FF;
  localparam logic [31:0] WNEW = 32'h1234_5678;

  fetch_stage #(
    .IMEM_DEPTH(256),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .imem_we     (imem_we),
    .imem_waddr  (imem_waddr),
    .imem_wdata  (imem_wdata),
    .pc          (pc),
    .pc_out      (pc_out),
    .instruction (instruction),
    .valid       (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] addr, input logic [31:0] data);
    imem_we    = 1'b1;
    imem_waddr = addr;
    imem_wdata = data;
    tick();
    imem_we    = 1'b0;
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                             input logic [31:0] e_pco, input logic e_vld);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".instr"}, instruction, e_ins);
    check({tag, ".pc_out"}, pc_out, e_pco);
    check({tag, ".valid"}, {31'h0, valid}, {31'h0, e_vld});
  endtask

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'h0;
    imem_we      = 1'b0;
    imem_waddr   = 8'h0;
    imem_wdata   = 32'h0;
    #2;
    expect_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);

    // Program load while held in reset.
    load(8'd0, W0);
    load(8'd1, W1);
    load(8'd2, W2);
    load(8'd3, W3);
    load(8'd16, W16);
    load(8'd255, W255);
    expect_ifid("reset_after_load", 32'h0, 32'h0, 32'h0, 1'b0);

    rst = 1'b1;
    tick(); expect_ifid("seq0", 32'h4, W0, 32'h4, 1'b1);
    tick(); expect_ifid("seq1", 32'h8, W1, 32'h8, 1'b1);

    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_ifid("freeze", 32'h8, W1, 32'h8, 1'b1);
    end
    freeze = 1'b0;
    tick(); expect_ifid("seq2", 32'hC, W2, 32'hC, 1'b1);
    tick(); expect_ifid("seq3", 32'h10, W3, 32'h10, 1'b1);

    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0042;
    tick(); expect_ifid("br_flush", 32'h40, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_ifid("br_target", 32'h44, W16, 32'h44, 1'b1);

    // Branch with freeze: branch wins; target 0x408 aliases to word 2.
    branch_taken = 1'b1;
    freeze       = 1'b1;
    branch_addr  = 32'h0000_0408;
    tick(); expect_ifid("brfrz_flush", 32'h408, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_ifid("brfrz_hold", 32'h408, 32'h0, 32'h0, 1'b0);
    freeze = 1'b0;
    tick(); expect_ifid("alias", 32'h40C, W2, 32'h40C, 1'b1);

    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick(); expect_ifid("wrap_flush", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_ifid("wrap_255", 32'h0, W255, 32'h0, 1'b1);
    tick(); expect_ifid("wrap_0", 32'h4, W0, 32'h4, 1'b1);

    // Write word 1 while it is being fetched: old contents come out, new ones later.
    load(8'd1, WNEW);
    expect_ifid("wr_old", 32'h8, W1, 32'h8, 1'b1);
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0004;
    tick(); expect_ifid("wr_br", 32'h4, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_ifid("wr_new", 32'h8, WNEW, 32'h8, 1'b1);

    // Asynchronous reset between edges, in the middle of a freeze.
    freeze = 1'b1;
    tick();
    #2;
    rst = 1'b0;
    #1;
    expect_ifid("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    tick();
    freeze = 1'b0;
    tick(); expect_ifid("rst_hold", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick(); expect_ifid("refetch0", 32'h4, W0, 32'h4, 1'b1);
    tick(); expect_ifid("refetch1", 32'h8, WNEW, 32'h8, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
